mem_arbiter: RTL

- Arbitrates cacheline refill and writeback traffic from the icache and the dcache onto the single memory path.
- Issues read commands to bmem and hands write lines to the cacheline adapter; both share that adapter's burst/handshake protocol.
- Routes each assembled 256-bit line back to the requester that owns it.
- Sits directly upstream of the cacheline adapter and drives its received, dfp_write, cache_waddr and cache_wdata inputs.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache refills and dcache writebacks onto one bmem/cacheline-adapter path.
// Define ARB_PERF_CNT_EN to add grant and dropped-response performance counters.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flush,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_read,
    output logic [255:0]      icache_rdata,
    output logic              icache_resp,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [255:0]      dcache_wdata,
    output logic [255:0]      dcache_rdata,
    output logic              dcache_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    input  logic              bmem_ready,
    output logic              received,
    output logic              adapt_write,
    output logic [ADDR_W-1:0] adapt_waddr,
    output logic [255:0]      adapt_wdata,
    input  logic              burst_ready,
    input  logic [ADDR_W-1:0] cacheline_addr,
    input  logic [255:0]      cacheline_data
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_icache_grants,
    output logic [31:0]       perf_dcache_grants,
    output logic [31:0]       perf_flush_drops
`endif
);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_BURST, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(31);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [255:0]      wdata_q;
    logic [CNT_W-1:0]  starve_q;
    logic              drop_q;
    logic              ic_req, dc_req, grant_i, grant_d, line_hit;

    // A same-cycle flush kills the icache request before it can win arbitration.
    assign ic_req   = icache_read && !branch_flush;
    assign dc_req   = dcache_read || dcache_write;
    assign line_hit = burst_ready && (((cacheline_addr ^ addr_q) & LINE_MASK) == '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ic_req && (starve_q == STARVE_MAX || !dc_req)) begin
                    grant_i = 1'b1;
                    state_d = RD_CMD;
                end else if (dc_req) begin
                    grant_d = 1'b1;
                    state_d = dcache_write ? WR_BURST : RD_CMD;
                end
            end
            RD_CMD:   if (bmem_ready)  state_d = RD_WAIT;
            RD_WAIT:  if (line_hit)    state_d = RESP;
            WR_BURST: if (burst_ready) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign bmem_read   = (state_q == RD_CMD);
    assign bmem_addr   = bmem_read ? addr_q : '0;
    assign adapt_write = (state_q == WR_BURST);
    assign adapt_waddr = adapt_write ? addr_q : '0;
    assign adapt_wdata = adapt_write ? wdata_q : '0;
    assign received    = (state_q == RD_WAIT) || adapt_write;
    assign icache_resp = (state_q == RESP) && (owner_q == OWN_I) && !drop_q;
    assign dcache_resp = (state_q == RESP) && (owner_q == OWN_D);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_q     <= '0;
            drop_q       <= 1'b0;
            icache_rdata <= '0;
            dcache_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i) begin
                owner_q <= OWN_I;
                addr_q  <= icache_addr & LINE_MASK;
            end else if (grant_d) begin
                owner_q <= OWN_D;
                addr_q  <= dcache_addr & LINE_MASK;
                if (dcache_write) wdata_q <= dcache_wdata;
            end

            if (grant_i)
                starve_q <= '0;
            else if (grant_d && icache_read && starve_q != STARVE_MAX)
                starve_q <= starve_q + 1'b1;

            // The dropped burst still runs to completion to keep the adapter in step.
            if (state_q == RESP)
                drop_q <= 1'b0;
            else if (branch_flush && owner_q == OWN_I && (state_q == RD_CMD || state_q == RD_WAIT))
                drop_q <= 1'b1;

            if (state_q == RD_WAIT && line_hit) begin
                if (owner_q == OWN_I) icache_rdata <= cacheline_data;
                else                  dcache_rdata <= cacheline_data;
            end else if (state_q == WR_BURST && burst_ready) begin
                dcache_rdata <= '0;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_icache_grants <= '0;
            perf_dcache_grants <= '0;
            perf_flush_drops   <= '0;
        end else begin
            if (grant_i) perf_icache_grants <= perf_icache_grants + 32'd1;
            if (grant_d) perf_dcache_grants <= perf_dcache_grants + 32'd1;
            if (state_q == RESP && owner_q == OWN_I && drop_q)
                perf_flush_drops <= perf_flush_drops + 32'd1;
        end
    end
`endif

endmodule
